// File: rtl/vga_sync_decoder.sv
// VGA receive timing: recovers pixel coordinates from active-low hsync/vsync, tracks lock, flags timing errors.
// Counters and status are registered; de/hpos/vpos decode the registered counters. There is no backpressure.
module vga_sync_decoder #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACT - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_line_prev_q, vs_line_prev_d;
  logic       frame_start_q, frame_start_d;
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  logic ls, fs, checking, viol;

  always_comb begin
    ls       = hs_prev_q & ~hs_in;
    fs       = ls & vs_line_prev_q & ~vs_in;
    checking = (state_q != SEARCH);

    // Line/frame length on an edge, or timeout when the terminal count passes without one.
    viol = checking & ((ls & (hcnt_q != H_LAST)) |
                       (~ls & (hcnt_q == H_LAST)) |
                       (fs & (vcnt_q != V_LAST)) |
                       (ls & ~fs & (vcnt_q == V_LAST)));

    hs_prev_d      = hs_in;
    vs_line_prev_d = ls ? vs_in : vs_line_prev_q;

    // Counters park at their timeout value so a stalled input cannot wrap them.
    if (ls)                  hcnt_d = '0;
    else if (hcnt_q == H_MAX) hcnt_d = hcnt_q;
    else                     hcnt_d = hcnt_q + 10'd1;

    vcnt_d = vcnt_q;
    if (fs)                               vcnt_d = '0;
    else if (ls && (vcnt_q != V_MAX))     vcnt_d = vcnt_q + 10'd1;

    state_d = state_q;
    case (state_q)
      SEARCH:  if (fs) state_d = CHECK;
      CHECK:   if (viol) state_d = SEARCH; else if (fs) state_d = LOCKED;
      LOCKED:  if (viol) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase

    frame_start_d = fs & ~viol & checking;
    err_d         = viol;
    err_count_d   = (viol && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEARCH;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      hs_prev_q      <= 1'b1;
      vs_line_prev_q <= 1'b1;
      frame_start_q  <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      hs_prev_q      <= hs_prev_d;
      vs_line_prev_q <= vs_line_prev_d;
      frame_start_q  <= frame_start_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
    end
  end

  always_comb begin
    locked      = (state_q == LOCKED);
    de          = locked &&
                  (hcnt_q >= H_ACT_LO) && (hcnt_q <= H_ACT_HI) &&
                  (vcnt_q >= V_ACT_LO) && (vcnt_q <= V_ACT_HI);
    hpos        = de ? hcnt_q - H_ACT_LO : '0;
    vpos        = de ? vcnt_q - V_ACT_LO : '0;
    frame_start = frame_start_q;
    err         = err_q;
    err_count   = err_count_q;
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 20x12 timing so that full frames stay short.
// A cycle-level reference model runs beside the DUT; directed scenarios add hand-computed expectations.
module tb_vga_sync_decoder;

  localparam int HS = 4, HB = 3, HA = 10, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5, VT = 12;
  localparam int H0 = HS + HB, V0 = VS + VB;

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       hs_in   = 1'b1;
  logic       vs_in   = 1'b0;
  logic [9:0] hpos, vpos;
  logic       de, locked, frame_start, err;
  logic [7:0] err_count;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in),
    .hpos(hpos), .vpos(vpos), .de(de), .locked(locked),
    .frame_start(frame_start), .err(err), .err_count(err_count)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: clocks since line start, lines since frame start, good frame starts seen.
  int m_h = 0, m_v = 0, m_good = 0, m_cnt = 0;
  bit m_hs = 1'b1, m_vs = 1'b1, m_err = 1'b0, m_fsp = 1'b0;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_good = 0; m_cnt = 0;
    m_hs = 1'b1; m_vs = 1'b1; m_err = 1'b0; m_fsp = 1'b0;
  endtask

  task automatic model_step();
    bit ls, fs, bad;
    ls  = m_hs && !hs_in;
    fs  = ls && m_vs && !vs_in;
    bad = 1'b0;
    if (m_good != 0) begin
      if (ls) bad = bad || (m_h + 1 != HT);
      else    bad = bad || (m_h + 1 == HT);
      if (fs)      bad = bad || (m_v + 1 != VT);
      else if (ls) bad = bad || (m_v + 1 == VT);
    end
    m_err = bad;
    m_fsp = fs && !bad && (m_good != 0);
    if (bad && m_cnt < 255) m_cnt++;
    if (bad) m_good = 0;
    else if (fs && m_good < 2) m_good++;
    m_h = ls ? 0 : ((m_h < HT) ? m_h + 1 : HT);
    if (fs) m_v = 0;
    else if (ls && m_v < VT) m_v++;
    m_hs = hs_in;
    if (ls) m_vs = vs_in;
  endtask

  initial begin : model
    forever begin
      @(posedge vga_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Observed statistics, compared against hand-computed values by the scenarios.
  int  de_total = 0, fs_pulses = 0, err_seen = 0, err_cyc = -1, lock_rise_cyc = -1;
  int  first_h = -1, first_v = -1, last_h = -1, last_v = -1;
  bit  first_seen = 1'b0, locked_prev = 1'b0, locked_seen = 1'b0;

  initial begin : compare
    forever begin
      bit e_de;
      @(negedge vga_clk);
      e_de = (m_good == 2) && (m_h >= H0) && (m_h <= H0 + HA - 1) &&
             (m_v >= V0) && (m_v <= V0 + VA - 1);
      check("de", de, e_de);
      check("hpos", hpos, e_de ? m_h - H0 : 0);
      check("vpos", vpos, e_de ? m_v - V0 : 0);
      check("locked", locked, m_good == 2);
      check("frame_start", frame_start, m_fsp);
      check("err", err, m_err);
      check("err_count", err_count, m_cnt);
      if (de === 1'b1) begin
        if (!first_seen) begin first_h = hpos; first_v = vpos; first_seen = 1'b1; end
        last_h = hpos; last_v = vpos; de_total++;
      end
      if (frame_start === 1'b1) fs_pulses++;
      if (err === 1'b1) begin err_seen++; err_cyc = cyc; end
      if (locked === 1'b1 && !locked_prev) lock_rise_cyc = cyc;
      if (locked === 1'b1) locked_seen = 1'b1;
      locked_prev = (locked === 1'b1);
    end
  end

  int line_cyc = 0, frame_cyc = 0;

  task automatic tick(input logic h, input logic v);
    @(negedge vga_clk);
    hs_in = h;
    vs_in = v;
  endtask

  // vs_next is the vsync level seen at the following line start; it changes mid-line.
  task automatic send_line(input int len, input logic vs_next);
    logic v;
    v = vs_in;
    for (int c = 0; c < len; c++) begin
      if (c == len / 2) v = vs_next;
      tick((c < HS) ? 1'b0 : 1'b1, v);
      if (c == 0) line_cyc = cyc;
    end
  endtask

  task automatic send_frame(input int n, input int nsync, input bit jitter, input int short_k);
    for (int k = 0; k < n; k++) begin
      int   len;
      logic vn;
      len = (k == short_k) ? HT - 1 : HT;
      if (jitter && $urandom_range(9, 0) == 0) len = $urandom_range(HT + 4, HT - 3);
      vn = (k + 1 < n) ? ((k + 1 < nsync) ? 1'b0 : 1'b1) : 1'b0;
      send_line(len, vn);
      if (k == 0) frame_cyc = line_cyc;
    end
  endtask

  initial begin : stim
    int e0, lc;
    repeat (2) @(negedge vga_clk);
    check("rst_de", de, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    check("rst_hpos", hpos, 0);
    @(negedge vga_clk); #2 rst_n = 1'b1;
    repeat (4) tick(1'b1, 1'b0);

    // Nominal frames: lock one cycle after the second frame start.
    send_frame(VT, VS, 1'b0, -1);
    check("t1_unlocked_after_f1", locked, 0);
    send_frame(VT, VS, 1'b0, -1);
    check("t1_lock_rise", lock_rise_cyc, frame_cyc + 1);
    send_frame(VT, VS, 1'b0, -1);
    check("t1_de_total", de_total, 2 * HA * VA);
    check("t1_fs_pulses", fs_pulses, 2);
    check("t1_first_h", first_h, 0);
    check("t1_first_v", first_v, 0);
    check("t1_last_h", last_h, HA - 1);
    check("t1_last_v", last_v, VA - 1);
    check("t1_locked", locked, 1);

    // One short line while locked, then relock.
    e0 = err_seen;
    send_frame(VT, VS, 1'b0, 6);
    check("t2_err_pulses", err_seen - e0, 1);
    check("t2_err_count", err_count, 1);
    check("t2_unlocked", locked, 0);
    send_frame(VT, VS, 1'b0, -1);
    check("t2_unlocked_f1", locked, 0);
    send_frame(VT, VS, 1'b0, -1);
    check("t2_relocked", locked, 1);

    // hsync stalls high: a single timeout error one line period after the last line start.
    e0 = err_seen;
    lc = line_cyc;
    repeat (3 * HT) tick(1'b1, 1'b0);
    check("t3_err_pulses", err_seen - e0, 1);
    check("t3_err_cycle", err_cyc, lc + HT + 1);
    check("t3_unlocked", locked, 0);
    check("t3_err_count", err_count, 2);

    // Short frame while checking.
    locked_seen = 1'b0;
    send_frame(VT - 1, VS, 1'b0, -1);
    e0 = err_seen;
    send_frame(VT, VS, 1'b0, -1);
    check("t4_err_pulses", err_seen - e0, 1);
    check("t4_never_locked", locked_seen, 0);
    check("t4_err_count", err_count, 3);

    // Randomized frame heights, vsync widths and line lengths.
    repeat (30) begin
      int n;
      n = ($urandom_range(99, 0) < 80) ? VT : $urandom_range(VT + 1, VT - 2);
      send_frame(n, $urandom_range(VS + 1, 1), 1'b1, -1);
    end

    // Two-line frames alternate entering CHECK and failing frame length.
    repeat (2 * HT) tick(1'b1, 1'b0);
    e0 = err_seen;
    repeat (600) send_frame(2, 1, 1'b0, -1);
    check("t5_err_pulses", err_seen - e0, 300);
    check("t5_err_count_sat", err_count, 255);

    // Asynchronous reset in the middle of an active line.
    send_frame(VT, VS, 1'b0, -1);
    send_frame(VT, VS, 1'b0, -1);
    check("t6_locked", locked, 1);
    for (int k = 0; k < 5; k++) send_line(HT, (k + 1 < VS) ? 1'b0 : 1'b1);
    for (int c = 0; c < 9; c++) tick((c < HS) ? 1'b0 : 1'b1, 1'b1);
    @(posedge vga_clk); #3;
    check("t6_de_before", de, 1);
    check("t6_hpos_before", hpos, 1);
    check("t6_vpos_before", vpos, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_de", de, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_hpos", hpos, 0);
    check("t6_rst_vpos", vpos, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_frame_start", frame_start, 0);
    repeat (3) tick(1'b1, 1'b0);
    @(negedge vga_clk); #2 rst_n = 1'b1;
    send_frame(VT, VS, 1'b0, -1);
    check("t6_unlocked_f1", locked, 0);
    send_frame(VT, VS, 1'b0, -1);
    check("t6_relock_rise", lock_rise_cyc, frame_cyc + 1);
    check("t6_relocked", locked, 1);
    repeat (5) tick(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
